packet_decoder: RTL and testbench

PACKET_DECODER -- requirements
Module: packet_decoder

---
 rtl/packet_decoder_if.sv | 24 ++
 rtl/packet_decoder.sv | 184 ++++++++++++++++++
 tb/tb_packet_decoder.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_decoder_if.sv
// Packet input bus and audio FIFO read port shared by the packet decoder and its source/sink.
interface packet_decoder_if #(
    parameter int AUDIO_BIT_WIDTH = 16
) ();
    logic                            packet_valid;
    logic [23:0]                     header;
    logic [3:0][55:0]                sub;
    logic                            busy;
    logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word;
    logic                            audio_valid;
    logic                            audio_ready;
    logic                            audio_block_start;
    logic                            audio_parity_error;

    modport master (
        output packet_valid, header, sub, audio_ready,
        input  busy, audio_sample_word, audio_valid, audio_block_start, audio_parity_error
    );

    modport slave (
        input  packet_valid, header, sub, audio_ready,
        output busy, audio_sample_word, audio_valid, audio_block_start, audio_parity_error
    );
endinterface

// File: rtl/packet_decoder.sv
// Data-island packet decoder: ACR capture, audio sample extraction into a FWFT FIFO,
// and checksummed InfoFrame field updates (AVI VIC, audio channel count).
module packet_decoder #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                clk_pixel,
    input  logic                reset_n,
    packet_decoder_if.slave     bus,
    output logic                audio_overflow,
    output logic [19:0]         acr_cts,
    output logic [19:0]         acr_n,
    output logic                acr_update,
    output logic [6:0]          avi_vic,
    output logic                avi_seen,
    output logic [2:0]          aif_channel_count,
    output logic                info_checksum_error,
    output logic                unknown_packet
);
    localparam int W  = AUDIO_BIT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACR,
        S_AUDIO,
        S_INFO_SUM,
        S_INFO_COMMIT
    } state_t;

    typedef struct packed {
        logic [W-1:0] right;
        logic [W-1:0] left;
        logic         block_start;
        logic         parity_error;
    } sample_t;

    function automatic logic [7:0] body_sum(input logic [55:0] s);
        logic [7:0] acc;
        acc = '0;
        for (int j = 0; j < 7; j++) acc = acc + s[8*j +: 8];
        return acc;
    endfunction

    state_t           state, state_next;
    logic             accept;
    logic [7:0]       hb0_in;
    logic [7:0]       hb0_q;
    logic [3:0]       present_q;
    logic [3:0]       block_q;
    logic [3:0][55:0] sub_q;
    logic [1:0]       idx_q;
    logic [7:0]       sum_q;
    logic [55:0]      cur_sub;

    assign hb0_in     = bus.header[7:0];
    assign accept     = (state == S_IDLE) && bus.packet_valid;
    assign cur_sub    = sub_q[idx_q];
    assign bus.busy   = (state != S_IDLE);
    assign acr_update = (state == S_ACR);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.packet_valid) begin
                    case (hb0_in)
                        8'h01:               state_next = S_ACR;
                        8'h02:               state_next = S_AUDIO;
                        8'h82, 8'h83, 8'h84: state_next = S_INFO_SUM;
                        default:             state_next = S_IDLE;
                    endcase
                end
            end
            S_ACR:         state_next = S_IDLE;
            S_AUDIO:       if (idx_q == 2'd3) state_next = S_IDLE;
            S_INFO_SUM:    if (idx_q == 2'd3) state_next = S_INFO_COMMIT;
            S_INFO_COMMIT: state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    // The header byte sum seeds the checksum so INFO_SUM only adds one body subpacket per cycle.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            hb0_q     <= '0;
            present_q <= '0;
            block_q   <= '0;
            sub_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
        end else if (accept) begin
            hb0_q     <= hb0_in;
            present_q <= bus.header[11:8];
            block_q   <= bus.header[23:20];
            sub_q     <= bus.sub;
            idx_q     <= '0;
            sum_q     <= bus.header[7:0] + bus.header[15:8] + bus.header[23:16];
        end else if (state == S_AUDIO || state == S_INFO_SUM) begin
            idx_q <= idx_q + 2'd1;
            sum_q <= sum_q + body_sum(cur_sub);
        end
    end

    sample_t     push_sample;
    sample_t     head;
    sample_t     fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push, pop, push_ok;

    always_comb begin
        push_sample.left         = cur_sub[23:24-W];
        push_sample.right        = cur_sub[47:48-W];
        push_sample.block_start  = block_q[idx_q];
        push_sample.parity_error = (^{cur_sub[23:0], cur_sub[50:48], cur_sub[51]})
                                 | (^{cur_sub[47:24], cur_sub[54:52], cur_sub[55]});
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign push       = (state == S_AUDIO) && present_q[idx_q];
    assign pop        = !fifo_empty && bus.audio_ready;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_pixel) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_sample;
    end

    assign head                   = fifo_mem[rd_ptr[AW-1:0]];
    assign bus.audio_valid        = !fifo_empty;
    assign bus.audio_sample_word  = fifo_empty ? '0 : {head.right, head.left};
    assign bus.audio_block_start  = !fifo_empty && head.block_start;
    assign bus.audio_parity_error = !fifo_empty && head.parity_error;

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            acr_cts             <= '0;
            acr_n               <= '0;
            avi_vic             <= '0;
            avi_seen            <= 1'b0;
            aif_channel_count   <= '0;
            info_checksum_error <= 1'b0;
            unknown_packet      <= 1'b0;
            audio_overflow      <= 1'b0;
        end else begin
            unknown_packet <= accept && !(hb0_in inside {8'h00, 8'h01, 8'h02, 8'h82, 8'h83, 8'h84});
            if (push && !push_ok) audio_overflow <= 1'b1;
            if (accept && hb0_in == 8'h01) begin
                acr_cts <= {bus.sub[0][11:8], bus.sub[0][23:16], bus.sub[0][31:24]};
                acr_n   <= {bus.sub[0][35:32], bus.sub[0][47:40], bus.sub[0][55:48]};
            end
            if (state == S_INFO_COMMIT) begin
                if (sum_q != 8'h00) begin
                    info_checksum_error <= 1'b1;
                end else if (hb0_q == 8'h82) begin
                    avi_vic  <= sub_q[0][38:32];
                    avi_seen <= 1'b1;
                end else if (hb0_q == 8'h84) begin
                    aif_channel_count <= sub_q[0][10:8];
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_decoder.sv
// Self-checking bench for packet_decoder: directed vector table, hand-written corner
// sequences and a randomized phase scored against a queue-based reference model.
module tb_packet_decoder;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic [W-1:0] left;
        logic [W-1:0] right;
        logic         bs;
        logic         perr;
    } sample_t;

    typedef struct {
        logic [23:0] header;
        logic [55:0] sub0;
        logic        exp_busy;
        logic        exp_unknown;
        logic        exp_acr_update;
        logic [19:0] exp_cts;
        logic [19:0] exp_n;
    } vec_t;

    logic        clk_pixel = 1'b0;
    logic        reset_n;
    logic        audio_overflow, acr_update, avi_seen, info_checksum_error, unknown_packet;
    logic [19:0] acr_cts, acr_n;
    logic [6:0]  avi_vic;
    logic [2:0]  aif_channel_count;

    packet_decoder_if #(.AUDIO_BIT_WIDTH(W)) bus ();

    packet_decoder #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_pixel           (clk_pixel),
        .reset_n             (reset_n),
        .bus                 (bus),
        .audio_overflow      (audio_overflow),
        .acr_cts             (acr_cts),
        .acr_n               (acr_n),
        .acr_update          (acr_update),
        .avi_vic             (avi_vic),
        .avi_seen            (avi_seen),
        .aif_channel_count   (aif_channel_count),
        .info_checksum_error (info_checksum_error),
        .unknown_packet      (unknown_packet)
    );

    always #5 clk_pixel = ~clk_pixel;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    sample_t     exp_q[$];
    logic        exp_overflow = 1'b0;
    logic [19:0] exp_cts = '0, exp_n = '0;
    logic [6:0]  exp_vic = '0;
    logic        exp_seen = 1'b0, exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: extract fields straight from the subpacket byte layout.
    function automatic sample_t model_sample(input logic [55:0] s, input logic bs);
        sample_t m;
        logic [23:0] l24, r24;
        l24    = s[23:0];
        r24    = s[47:24];
        m.left  = W'(l24 >> (24 - W));
        m.right = W'(r24 >> (24 - W));
        m.bs    = bs;
        m.perr  = ($countones({s[23:0], s[51:48]}) % 2 != 0) || ($countones({s[47:24], s[55:52]}) % 2 != 0);
        return m;
    endfunction

    task automatic model_audio(input logic [23:0] h, input logic [3:0][55:0] s);
        for (int k = 0; k < 4; k++) begin
            if (h[8+k]) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(model_sample(s[k], h[20+k]));
                else                      exp_overflow = 1'b1;
            end
        end
    endtask

    function automatic logic [55:0] mk_audio(input logic [23:0] l, input logic [23:0] r,
                                             input logic [5:0] aux, input logic bad_l, input logic bad_r);
        logic [55:0] s;
        s          = '0;
        s[23:0]    = l;
        s[47:24]   = r;
        s[50:48]   = aux[2:0];
        s[54:52]   = aux[5:3];
        s[51]      = ($countones({l, aux[2:0]}) % 2 == 1) ^ bad_l;
        s[55]      = ($countones({r, aux[5:3]}) % 2 == 1) ^ bad_r;
        return s;
    endfunction

    function automatic logic [3:0][55:0] with_checksum(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [3:0][55:0] o;
        logic [7:0]       total;
        o     = s;
        total = h[7:0] + h[15:8] + h[23:16];
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 7; j++)
                if (!(k == 0 && j == 0)) total = total + o[k][8*j +: 8];
        o[0][7:0] = 8'h00 - total;
        return o;
    endfunction

    function automatic logic [3:0][55:0] rand_subs();
        logic [3:0][55:0] s;
        for (int k = 0; k < 4; k++) s[k] = 56'({$urandom, $urandom});
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #2;
    endtask

    task automatic send(input logic [23:0] h, input logic [3:0][55:0] s);
        bus.packet_valid = 1'b1;
        bus.header       = h;
        bus.sub          = s;
        tick();
        bus.packet_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        check({name, " returns idle"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic drain(input string name);
        int n = 0;
        ready_mode = 1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({name, " all samples seen"}, 64'(exp_q.size()), 64'(0));
        check({name, " fifo empty"}, 64'(bus.audio_valid), 64'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        exp_overflow = 1'b0;
        exp_cts = '0; exp_n = '0; exp_vic = '0; exp_seen = 1'b0; exp_err = 1'b0;
        tick();
    endtask

    task automatic check_all_outputs(input string name);
        check({name, " busy"},        64'(bus.busy),               64'(0));
        check({name, " audio_valid"}, 64'(bus.audio_valid),        64'(0));
        check({name, " sample"},      64'(bus.audio_sample_word),  64'(0));
        check({name, " block"},       64'(bus.audio_block_start),  64'(0));
        check({name, " parity"},      64'(bus.audio_parity_error), 64'(0));
        check({name, " overflow"},    64'(audio_overflow),         64'(0));
        check({name, " acr_cts"},     64'(acr_cts),                64'(0));
        check({name, " acr_n"},       64'(acr_n),                  64'(0));
        check({name, " acr_update"},  64'(acr_update),             64'(0));
        check({name, " avi_vic"},     64'(avi_vic),                64'(0));
        check({name, " avi_seen"},    64'(avi_seen),               64'(0));
        check({name, " aif_count"},   64'(aif_channel_count),      64'(0));
        check({name, " info_err"},    64'(info_checksum_error),    64'(0));
        check({name, " unknown"},     64'(unknown_packet),         64'(0));
    endtask

    // Sink: picks audio_ready for the coming edge and scores any sample popped on it.
    initial begin
        logic r;
        sample_t e;
        bus.audio_ready = 1'b0;
        forever begin
            @(negedge clk_pixel);
            case (ready_mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.audio_ready = r;
            if (reset_n && bus.audio_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("unexpected audio sample", 64'(bus.audio_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("audio left",   64'(bus.audio_sample_word[0]),  64'(e.left));
                    check("audio right",  64'(bus.audio_sample_word[1]),  64'(e.right));
                    check("audio block",  64'(bus.audio_block_start),     64'(e.bs));
                    check("audio parity", 64'(bus.audio_parity_error),    64'(e.perr));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             tv[7];
        logic [3:0][55:0] s;
        logic [23:0]      h;
        logic [7:0]       hb0;
        logic             good;

        reset_n          = 1'b0;
        bus.packet_valid = 1'b0;
        bus.header       = '0;
        bus.sub          = '0;
        @(posedge clk_pixel);
        #2;
        repeat (3) tick();
        check_all_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Single-packet dispatch table, observed one cycle after the latch.
        tv[0] = '{24'h000001, 56'h0018_0000_1800_00, 1'b1, 1'b0, 1'b1, 20'h01800, 20'h01800};
        tv[1] = '{24'h000000, 56'h1111_2222_3333_44, 1'b0, 1'b0, 1'b0, 20'h01800, 20'h01800};
        tv[2] = '{24'h000005, 56'h0000_0000_0000_00, 1'b0, 1'b1, 1'b0, 20'h01800, 20'h01800};
        tv[3] = '{24'h000001, 56'h12_3456_789A_BCDE, 1'b1, 1'b0, 1'b1, 20'hC9A78, 20'h63412};
        tv[4] = '{24'hABCDFF, 56'hFFFF_FFFF_FFFF_FF, 1'b0, 1'b1, 1'b0, 20'hC9A78, 20'h63412};
        tv[5] = '{24'h000002, 56'h0000_0000_0000_00, 1'b1, 1'b0, 1'b0, 20'hC9A78, 20'h63412};
        tv[6] = '{24'h000081, 56'h0000_0000_0000_00, 1'b0, 1'b1, 1'b0, 20'hC9A78, 20'h63412};
        for (int i = 0; i < 7; i++) begin
            send(tv[i].header, {56'h0, 56'h0, 56'h0, tv[i].sub0});
            @(negedge clk_pixel);
            check($sformatf("table[%0d] busy", i),       64'(bus.busy),       64'(tv[i].exp_busy));
            check($sformatf("table[%0d] unknown", i),    64'(unknown_packet), 64'(tv[i].exp_unknown));
            check($sformatf("table[%0d] acr_update", i), 64'(acr_update),     64'(tv[i].exp_acr_update));
            check($sformatf("table[%0d] acr_cts", i),    64'(acr_cts),        64'(tv[i].exp_cts));
            check($sformatf("table[%0d] acr_n", i),      64'(acr_n),          64'(tv[i].exp_n));
            tick();
            wait_idle($sformatf("table[%0d]", i));
            exp_cts = tv[i].exp_cts;
            exp_n   = tv[i].exp_n;
        end
        check("table no unknown after pulse", 64'(unknown_packet), 64'(0));

        // Full audio packet: four samples in order, block flag on the first, busy exactly 4 cycles.
        ready_mode = 1;
        h = 24'h100F02;
        for (int k = 0; k < 4; k++) s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom), 1'b0, 1'b0);
        model_audio(h, s);
        send(h, s);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_pixel);
            check($sformatf("audio busy cycle %0d", c), 64'(bus.busy), 64'(1));
        end
        @(negedge clk_pixel);
        check("audio busy after 4 cycles", 64'(bus.busy), 64'(0));
        tick();
        drain("audio4");

        // Sparse packet: subpackets 0 and 2 only, second one with a corrupted parity bit.
        h = 24'h000502;
        for (int k = 0; k < 4; k++) s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom), 1'b0, k == 2);
        model_audio(h, s);
        send(h, s);
        wait_idle("audio sparse");
        drain("audio sparse");

        // Overflow: 12 samples into an 8-deep FIFO with the sink stalled.
        ready_mode = 0;
        tick();
        for (int p = 0; p < 3; p++) begin
            h = 24'h000F02;
            for (int k = 0; k < 4; k++) s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom), 1'b0, 1'b0);
            model_audio(h, s);
            send(h, s);
            wait_idle("overflow fill");
        end
        check("overflow flag", 64'(audio_overflow), 64'(exp_overflow));
        check("overflow fifo holds data", 64'(bus.audio_valid), 64'(1));
        drain("overflow");
        check("overflow sticky", 64'(audio_overflow), 64'(1));

        do_reset();
        check("reset clears overflow", 64'(audio_overflow), 64'(0));
        reset_n = 1'b1;
        tick();

        // Push onto a full FIFO in the same cycle as a pop must not overflow.
        ready_mode = 0;
        tick();
        for (int p = 0; p < 2; p++) begin
            h = 24'h000F02;
            for (int k = 0; k < 4; k++) s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom), 1'b0, 1'b0);
            model_audio(h, s);
            send(h, s);
            wait_idle("full fill");
        end
        h = 24'h000102;
        for (int k = 0; k < 4; k++) s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom), 1'b0, 1'b0);
        exp_q.push_back(model_sample(s[0], 1'b0));
        send(h, s);
        ready_mode = 1;
        wait_idle("full push+pop");
        drain("full push+pop");
        check("full push+pop no overflow", 64'(audio_overflow), 64'(0));

        // AVI InfoFrame: good checksum updates VIC; busy spans 4 sum cycles plus commit.
        h = 24'h0D0282;
        s = rand_subs();
        s[0][39:32] = 8'd16;
        s = with_checksum(h, s);
        send(h, s);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_pixel);
            check($sformatf("info busy cycle %0d", c), 64'(bus.busy), 64'(1));
        end
        @(negedge clk_pixel);
        check("info busy after commit", 64'(bus.busy), 64'(0));
        check("avi_vic", 64'(avi_vic), 64'(16));
        check("avi_seen", 64'(avi_seen), 64'(1));
        check("info_err clean", 64'(info_checksum_error), 64'(0));
        tick();

        s[0][39:32] = 8'd31;
        s = with_checksum(h, s);
        s[0][7:0] = s[0][7:0] + 8'd1;
        send(h, s);
        wait_idle("avi bad");
        check("bad checksum flag", 64'(info_checksum_error), 64'(1));
        check("bad checksum vic kept", 64'(avi_vic), 64'(16));

        h = 24'h0A0184;
        s = rand_subs();
        s[0][10:8] = 3'd5;
        s = with_checksum(h, s);
        send(h, s);
        wait_idle("aif");
        check("aif channel count", 64'(aif_channel_count), 64'(5));

        h = 24'h0A0183;
        s = with_checksum(h, rand_subs());
        send(h, s);
        wait_idle("spd");
        check("0x83 leaves vic", 64'(avi_vic), 64'(16));
        check("0x83 leaves aif", 64'(aif_channel_count), 64'(5));

        // packet_valid during AUDIO is ignored.
        do_reset();
        reset_n = 1'b1;
        tick();
        ready_mode = 1;
        h = 24'h000102;
        for (int k = 0; k < 4; k++) s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom), 1'b0, 1'b0);
        model_audio(h, s);
        send(h, s);
        tick();
        send(24'h000001, {56'h0, 56'h0, 56'h0, 56'h12_3456_789A_BCDE});
        @(negedge clk_pixel);
        check("ignored acr_update", 64'(acr_update), 64'(0));
        check("ignored acr_cts", 64'(acr_cts), 64'(exp_cts));
        tick();
        wait_idle("ignore");
        drain("ignore");

        // Reset during INFO_SUM discards the packet.
        h = 24'h0D0282;
        s = rand_subs();
        s[0][39:32] = 8'd99;
        s = with_checksum(h, s);
        send(h, s);
        tick();
        do_reset();
        check_all_outputs("reset mid-info");
        reset_n = 1'b1;
        repeat (6) tick();
        check("no vic after reset", 64'(avi_vic), 64'(0));
        check("no seen after reset", 64'(avi_seen), 64'(0));

        // Randomized mix against the reference model.
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    int n = 0;
                    while (exp_q.size() > DEPTH - 5 && n < 200) begin
                        tick();
                        n++;
                    end
                    check("rand fifo drains", 64'(exp_q.size() > DEPTH - 5), 64'(0));
                    h = {8'($urandom), 8'($urandom), 8'h02};
                    for (int k = 0; k < 4; k++)
                        s[k] = mk_audio(24'($urandom), 24'($urandom), 6'($urandom),
                                        $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                    model_audio(h, s);
                    send(h, s);
                    wait_idle("rand audio");
                end
                6, 7: begin
                    h = {16'($urandom), 8'h01};
                    s = rand_subs();
                    exp_cts = {s[0][11:8], s[0][23:16], s[0][31:24]};
                    exp_n   = {s[0][35:32], s[0][47:40], s[0][55:48]};
                    send(h, s);
                    @(negedge clk_pixel);
                    check("rand acr_update", 64'(acr_update), 64'(1));
                    check("rand acr_cts", 64'(acr_cts), 64'(exp_cts));
                    check("rand acr_n", 64'(acr_n), 64'(exp_n));
                    tick();
                    wait_idle("rand acr");
                end
                8: begin
                    hb0 = 8'($urandom);
                    while (hb0 inside {8'h00, 8'h01, 8'h02, 8'h82, 8'h83, 8'h84}) hb0 = 8'($urandom);
                    send({16'($urandom), hb0}, rand_subs());
                    @(negedge clk_pixel);
                    check("rand unknown", 64'(unknown_packet), 64'(1));
                    check("rand unknown busy", 64'(bus.busy), 64'(0));
                    tick();
                end
                default: begin
                    h = {16'($urandom), 8'h82};
                    s = with_checksum(h, rand_subs());
                    good = 1'($urandom_range(0, 1));
                    if (!good) s[0][7:0] = s[0][7:0] ^ 8'h5A;
                    if (good) begin
                        exp_vic  = s[0][38:32];
                        exp_seen = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                    send(h, s);
                    wait_idle("rand info");
                    check("rand avi_vic", 64'(avi_vic), 64'(exp_vic));
                    check("rand avi_seen", 64'(avi_seen), 64'(exp_seen));
                    check("rand info_err", 64'(info_checksum_error), 64'(exp_err));
                end
            endcase
        end
        drain("random");
        check("random overflow", 64'(audio_overflow), 64'(exp_overflow));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
